// File: rtl/cpl_split.sv
// cpl_split: completer-side splitter for memory-read requests.
// Cuts one request (start address, byte count) into completion descriptors
// bounded by the max payload size and, optionally, the 64B read completion
// boundary for unaligned start addresses.
module cpl_split #(
    parameter bit WITH_RCB = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  ms_pld_i,
    input  logic        req_vld_i,
    output logic        req_rdy_o,
    input  logic [63:0] req_addr_i,
    input  logic [12:0] req_bcnt_i,
    input  logic [7:0]  req_tag_i,
    output logic        cpl_vld_o,
    input  logic        cpl_rdy_i,
    output logic [63:0] cpl_addr_o,
    output logic [6:0]  cpl_lowaddr_o,
    output logic [10:0] cpl_len_o,
    output logic [12:0] cpl_bcnt_o,
    output logic [7:0]  cpl_tag_o,
    output logic        cpl_last_o,
    output logic        busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;

    // Held low through reset so req_rdy only rises from the first edge after release
    logic        rdy_en_q;

    logic [63:0] addr_q, addr_d;
    logic [12:0] rem_q,  rem_d;
    logic [7:0]  tag_q,  tag_d;
    logic [10:0] mps_q,  mps_d;
    logic [10:0] len_q,  len_d;
    logic        last_q, last_d;

    logic        accept;
    logic        take;
    logic [12:0] req_rem;
    logic [10:0] req_mps;
    logic [63:0] nxt_addr;
    logic [12:0] nxt_rem;

    // Lowest set bit wins; an all-zero field falls back to 128B
    function automatic logic [10:0] mps_bytes(input logic [3:0] ms);
        logic [10:0] r;
        if (ms[0])      r = 11'd128;
        else if (ms[1]) r = 11'd256;
        else if (ms[2]) r = 11'd512;
        else if (ms[3]) r = 11'd1024;
        else            r = 11'd128;
        return r;
    endfunction

    // Length of the completion starting at addr: distance to the next cut
    // boundary, clipped to the bytes still owed. Result is 1..1024.
    function automatic logic [10:0] cut_len(input logic [63:0] addr,
                                            input logic [12:0] rem,
                                            input logic [10:0] mps);
        logic [10:0] bsz;
        logic [10:0] offs;
        logic [11:0] chunk;
        logic [10:0] r;
        if (WITH_RCB && (addr[5:0] != 6'd0)) bsz = 11'd64;
        else                                 bsz = mps;
        offs  = addr[10:0] & (bsz - 11'd1);
        chunk = {1'b0, bsz} - {1'b0, offs};
        // When chunk < rem the chunk fits in 11 bits; otherwise rem <= chunk <= 1024
        if ({1'b0, chunk} < rem) r = chunk[10:0];
        else                     r = rem[10:0];
        return r;
    endfunction

    assign accept   = (state_q == IDLE) && rdy_en_q && req_vld_i;
    assign take     = (state_q == SEND) && cpl_rdy_i;
    assign req_rem  = (req_bcnt_i == 13'd0) ? 13'd4096 : req_bcnt_i;
    assign req_mps  = mps_bytes(ms_pld_i);
    assign nxt_addr = addr_q + {53'd0, len_q};
    assign nxt_rem  = rem_q - {2'b00, len_q};

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next-state: leave IDLE on accept, return once the last descriptor is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)          state_d = SEND;
            SEND: if (take && last_q)  state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        req_rdy_o = 1'b0;
        cpl_vld_o = 1'b0;
        busy_o    = 1'b0;
        case (state_q)
            IDLE: req_rdy_o = rdy_en_q;
            SEND: begin
                cpl_vld_o = 1'b1;
                busy_o    = 1'b1;
            end
            default: ;
        endcase
    end

    // Descriptor next-state: load on accept, advance on a non-last handshake
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        tag_d  = tag_q;
        mps_d  = mps_q;
        len_d  = len_q;
        last_d = last_q;
        if (accept) begin
            addr_d = req_addr_i;
            rem_d  = req_rem;
            tag_d  = req_tag_i;
            mps_d  = req_mps;
            len_d  = cut_len(req_addr_i, req_rem, req_mps);
            last_d = ({2'b00, len_d} == req_rem);
        end else if (take && !last_q) begin
            addr_d = nxt_addr;
            rem_d  = nxt_rem;
            len_d  = cut_len(nxt_addr, nxt_rem, mps_q);
            last_d = ({2'b00, len_d} == nxt_rem);
        end
    end

    // Descriptor registers; they only move on accept or take, so a stalled
    // descriptor holds steady under backpressure
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= 64'd0;
            rem_q  <= 13'd0;
            tag_q  <= 8'd0;
            mps_q  <= 11'd0;
            len_q  <= 11'd0;
            last_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            tag_q  <= tag_d;
            mps_q  <= mps_d;
            len_q  <= len_d;
            last_q <= last_d;
        end
    end

    assign cpl_addr_o    = addr_q;
    assign cpl_lowaddr_o = addr_q[6:0];
    assign cpl_len_o     = len_q;
    assign cpl_bcnt_o    = rem_q;
    assign cpl_tag_o     = tag_q;
    assign cpl_last_o    = last_q;

endmodule

// File: tb/tb_cpl_split.sv
// Bench for cpl_split: two instances (WITH_RCB=0 and WITH_RCB=1) driven by
// directed and random requests, compared against a descriptor-list model.
module tb_cpl_split;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ms_pld;
    logic [63:0] req_addr;
    logic [12:0] req_bcnt;
    logic [7:0]  req_tag;

    logic        req_vld  [2];
    logic        cpl_rdy  [2];
    logic        req_rdy  [2];
    logic        cpl_vld  [2];
    logic        cpl_last [2];
    logic        busy     [2];
    logic [63:0] cpl_addr [2];
    logic [6:0]  cpl_low  [2];
    logic [10:0] cpl_len  [2];
    logic [12:0] cpl_bcnt [2];
    logic [7:0]  cpl_tag  [2];

    int nerr = 0;
    int nchk = 0;

    logic [63:0] exp_addr [$];
    int          exp_len  [$];
    int          exp_bcnt [$];
    bit          exp_last [$];

    always #5 clk = ~clk;

    cpl_split #(.WITH_RCB(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .ms_pld_i(ms_pld),
        .req_vld_i(req_vld[0]), .req_rdy_o(req_rdy[0]),
        .req_addr_i(req_addr), .req_bcnt_i(req_bcnt), .req_tag_i(req_tag),
        .cpl_vld_o(cpl_vld[0]), .cpl_rdy_i(cpl_rdy[0]),
        .cpl_addr_o(cpl_addr[0]), .cpl_lowaddr_o(cpl_low[0]),
        .cpl_len_o(cpl_len[0]), .cpl_bcnt_o(cpl_bcnt[0]),
        .cpl_tag_o(cpl_tag[0]), .cpl_last_o(cpl_last[0]), .busy_o(busy[0])
    );

    cpl_split #(.WITH_RCB(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .ms_pld_i(ms_pld),
        .req_vld_i(req_vld[1]), .req_rdy_o(req_rdy[1]),
        .req_addr_i(req_addr), .req_bcnt_i(req_bcnt), .req_tag_i(req_tag),
        .cpl_vld_o(cpl_vld[1]), .cpl_rdy_i(cpl_rdy[1]),
        .cpl_addr_o(cpl_addr[1]), .cpl_lowaddr_o(cpl_low[1]),
        .cpl_len_o(cpl_len[1]), .cpl_bcnt_o(cpl_bcnt[1]),
        .cpl_tag_o(cpl_tag[1]), .cpl_last_o(cpl_last[1]), .busy_o(busy[1])
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: walk the request byte range, cutting at the 64B boundary
    // first when the address is unaligned (RCB variant), else at MPS.
    task automatic build_model(input bit rcb, input logic [63:0] a_in,
                               input logic [12:0] b, input logic [3:0] ms);
        logic [63:0] a;
        int rem, mps, bsz, off, ln;
        exp_addr.delete(); exp_len.delete(); exp_bcnt.delete(); exp_last.delete();
        a   = a_in;
        rem = (b == 13'd0) ? 4096 : int'(b);
        if (ms[0])      mps = 128;
        else if (ms[1]) mps = 256;
        else if (ms[2]) mps = 512;
        else if (ms[3]) mps = 1024;
        else            mps = 128;
        while (rem > 0) begin
            bsz = (rcb && (a % 64 != 0)) ? 64 : mps;
            off = int'(a % bsz);
            ln  = bsz - off;
            if (ln > rem) ln = rem;
            exp_addr.push_back(a);
            exp_len.push_back(ln);
            exp_bcnt.push_back(rem);
            exp_last.push_back(ln == rem);
            a   = a + 64'(ln);
            rem = rem - ln;
        end
    endtask

    task automatic check_desc(input int w, input int k, input logic [7:0] tg);
        string s;
        s = $sformatf("d%0d_k%0d", w, k);
        chk({s, "_vld"},  cpl_vld[w],  1);
        chk({s, "_addr"}, cpl_addr[w], exp_addr[k]);
        chk({s, "_low"},  cpl_low[w],  exp_addr[k] & 64'h7f);
        chk({s, "_len"},  cpl_len[w],  exp_len[k]);
        chk({s, "_bcnt"}, cpl_bcnt[w], exp_bcnt[k]);
        chk({s, "_tag"},  cpl_tag[w],  tg);
        chk({s, "_last"}, cpl_last[w], exp_last[k]);
        chk({s, "_rdy"},  req_rdy[w],  0);
        chk({s, "_busy"}, busy[w],     1);
    endtask

    // Issue one request on instance w and walk all its descriptors.
    // Called at a falling edge; returns at a falling edge.
    task automatic do_req(input int w, input logic [63:0] a, input logic [12:0] b,
                          input logic [3:0] ms, input logic [7:0] tg,
                          input bit bp, input int exp_n);
        int n;
        build_model(w == 1, a, b, ms);
        for (int i = 0; i < 8 && req_rdy[w] !== 1'b1; i++) @(negedge clk);
        chk($sformatf("d%0d_rdy_wait", w), req_rdy[w], 1);
        ms_pld   = ms;
        req_addr = a;
        req_bcnt = b;
        req_tag  = tg;
        req_vld[w] = 1'b1;
        cpl_rdy[w] = 1'b1;
        @(negedge clk);
        req_vld[w] = 1'b0;
        // MPS changes during the request must not matter
        ms_pld   = 4'($urandom);
        req_addr = {$urandom, $urandom};
        req_bcnt = 13'($urandom);
        req_tag  = 8'($urandom);
        n = 0;
        for (int k = 0; k < exp_addr.size(); k++) begin
            if (bp && k == (exp_addr.size() > 1 ? 1 : 0)) begin
                cpl_rdy[w] = 1'b0;
                repeat (3) begin
                    check_desc(w, k, tg);
                    @(negedge clk);
                end
                cpl_rdy[w] = 1'b1;
            end
            check_desc(w, k, tg);
            if (cpl_vld[w] === 1'b1) n++;
            @(negedge clk);
        end
        chk($sformatf("d%0d_end_vld", w),  cpl_vld[w], 0);
        chk($sformatf("d%0d_end_rdy", w),  req_rdy[w], 1);
        chk($sformatf("d%0d_end_busy", w), busy[w],    0);
        if (exp_n >= 0) chk($sformatf("d%0d_count", w), 64'(n), 64'(exp_n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra;
        int          w;
        rst = 1'b1;
        ms_pld = 4'd1; req_addr = '0; req_bcnt = '0; req_tag = '0;
        req_vld[0] = 1'b0; req_vld[1] = 1'b0;
        cpl_rdy[0] = 1'b0; cpl_rdy[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values on both instances
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_rdy", i),  req_rdy[i],  0);
            chk($sformatf("rst%0d_vld", i),  cpl_vld[i],  0);
            chk($sformatf("rst%0d_busy", i), busy[i],     0);
            chk($sformatf("rst%0d_last", i), cpl_last[i], 0);
            chk($sformatf("rst%0d_addr", i), cpl_addr[i], 0);
            chk($sformatf("rst%0d_low", i),  cpl_low[i],  0);
            chk($sformatf("rst%0d_len", i),  cpl_len[i],  0);
            chk($sformatf("rst%0d_bcnt", i), cpl_bcnt[i], 0);
            chk($sformatf("rst%0d_tag", i),  cpl_tag[i],  0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rel_rdy0", req_rdy[0], 1);
        chk("rel_rdy1", req_rdy[1], 1);

        // 512B at 0x1000, MPS 128, with a 3-cycle stall on the 2nd descriptor
        do_req(1, 64'h1000, 13'd512, 4'b0001, 8'h11, 1'b1, 4);
        // Unaligned start with RCB: 48 then 152
        do_req(1, 64'h1010, 13'd200, 4'b0010, 8'h22, 1'b0, 2);
        // Unaligned start without RCB: 112, 128, 60
        do_req(0, 64'h1010, 13'd300, 4'b0001, 8'h33, 1'b0, 3);
        // Byte count 0 means 4096, MPS 1024
        do_req(1, 64'h0, 13'd0, 4'b1000, 8'h44, 1'b0, 4);
        do_req(0, 64'h0, 13'd0, 4'b1000, 8'h45, 1'b1, 4);
        // Address wrap past 2^64
        do_req(0, 64'hFFFF_FFFF_FFFF_FFC0, 13'd256, 4'b0001, 8'h55, 1'b0, 3);
        // ms_pld=0 decodes as 128B; multi-bit field uses lowest bit
        do_req(1, 64'h40, 13'd300, 4'b0000, 8'h66, 1'b0, 3);
        do_req(1, 64'h100, 13'd600, 4'b0110, 8'h67, 1'b0, 3);
        // Single-byte request
        do_req(1, 64'h7f, 13'd1, 4'b0100, 8'h68, 1'b0, 1);

        // Reset during the 2nd descriptor drops the request
        build_model(1'b1, 64'h2000, 13'd512, 4'b0001);
        ms_pld = 4'b0001; req_addr = 64'h2000; req_bcnt = 13'd512; req_tag = 8'h77;
        req_vld[1] = 1'b1; cpl_rdy[1] = 1'b1;
        @(negedge clk);
        req_vld[1] = 1'b0;
        check_desc(1, 0, 8'h77);
        @(negedge clk);
        check_desc(1, 1, 8'h77);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld",  cpl_vld[1],  0);
        chk("mid_rst_rdy",  req_rdy[1],  0);
        chk("mid_rst_busy", busy[1],     0);
        chk("mid_rst_addr", cpl_addr[1], 0);
        chk("mid_rst_len",  cpl_len[1],  0);
        chk("mid_rst_bcnt", cpl_bcnt[1], 0);
        chk("mid_rst_last", cpl_last[1], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", req_rdy[1], 1);
        chk("post_rst_vld", cpl_vld[1], 0);
        do_req(1, 64'h3030, 13'd100, 4'b0010, 8'h78, 1'b0, 2);

        // Random requests against the model
        for (int i = 0; i < 40; i++) begin
            w  = int'($urandom_range(1, 0));
            ra = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) ra = 64'hFFFF_FFFF_FFFF_F000 | 64'($urandom_range(4095, 0));
            do_req(w, ra, 13'($urandom_range(4096, 0)), 4'($urandom),
                   8'($urandom), ($urandom_range(2, 0) == 0), -1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
